vec_sweep_monitor: RTL

VEC_SWEEP_MONITOR -- requirements
Module: vec_sweep_monitor

---
 rtl/vsm_pkg.sv | 13 +
 rtl/vsm_misr.sv | 21 ++
 rtl/vec_sweep_monitor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/vsm_pkg.sv
// Shared types and constants for the vector sweep monitor.
package vsm_pkg;
  localparam int          SIG_W     = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;
endpackage

// File: rtl/vsm_misr.sv
// 16-bit response signature register (CRC-CCITT feedback, data xored in LSBs).
module vsm_misr
  import vsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/vec_sweep_monitor.sv
// Exhaustive stimulus sweep with settle/sample stability check and response signature.
// Define VSM_GRAY_EN to drive the stimulus in Gray code instead of binary.
module vec_sweep_monitor
  import vsm_pkg::*;
#(
  parameter int              IN_W       = 13,
  parameter int              OUT_W      = 5,
  parameter int              SETTLE_CYC = 4,
  parameter logic [IN_W-1:0] VEC_LAST   = {IN_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  stim_o,
  input  logic [OUT_W-1:0] resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      sig_o,
  output logic [15:0]      unstable_cnt_o,
  output logic [IN_W-1:0]  first_bad_o,
  output logic             bad_valid_o
);

  state_e           r_state, w_state_nxt;
  logic [IN_W-1:0]  r_vec, r_stim, r_first_bad;
  logic [IN_W-1:0]  w_vec_inc, w_stim_inc;
  logic [3:0]       r_cnt;
  logic [OUT_W-1:0] r_resp_q;
  logic [15:0]      r_unst;
  logic             r_bad_valid;
  logic             w_clr, w_sample, w_unstable, w_last;
  logic [SIG_W-1:0] w_din;

  assign w_clr      = ((r_state == IDLE) || (r_state == DONE)) && start;
  assign w_sample   = (r_state == SAMPLE);
  assign w_unstable = w_sample && (resp_i != r_resp_q);
  assign w_last     = (r_vec == VEC_LAST);
  assign w_vec_inc  = r_vec + 1'b1;

  // Stimulus is loaded on entry to APPLY so it is already steady during APPLY.
`ifdef VSM_GRAY_EN
  assign w_stim_inc = w_vec_inc ^ (w_vec_inc >> 1);
`else
  assign w_stim_inc = w_vec_inc;
`endif

  always_comb begin
    w_din             = '0;
    w_din[OUT_W-1:0]  = resp_i;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = APPLY;
      APPLY:      w_state_nxt = SETTLE;
      SETTLE:     if (r_cnt == 4'd0) w_state_nxt = SAMPLE;
      SAMPLE:     w_state_nxt = w_last ? DONE : APPLY;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_vec       <= '0;
      r_stim      <= '0;
      r_cnt       <= '0;
      r_resp_q    <= '0;
      r_unst      <= '0;
      r_first_bad <= '0;
      r_bad_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE, DONE: if (start) begin
          r_vec       <= '0;
          r_stim      <= '0;
          r_unst      <= '0;
          r_first_bad <= '0;
          r_bad_valid <= 1'b0;
        end
        APPLY: r_cnt <= 4'(SETTLE_CYC - 1);
        SETTLE: begin
          r_resp_q <= resp_i;
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 1'b1;
        end
        SAMPLE: begin
          if (w_unstable) begin
            if (r_unst != 16'hFFFF) r_unst <= r_unst + 16'd1;
            if (!r_bad_valid) begin
              r_first_bad <= r_vec;
              r_bad_valid <= 1'b1;
            end
          end
          // vec stops at VEC_LAST; the increment is never committed past it.
          if (!w_last) begin
            r_vec  <= w_vec_inc;
            r_stim <= w_stim_inc;
          end
        end
        default: ;
      endcase
    end
  end

  vsm_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_sample),
    .din (w_din),
    .sig (sig_o)
  );

  assign stim_o         = r_stim;
  assign busy_o         = (r_state == APPLY) || (r_state == SETTLE) || (r_state == SAMPLE);
  assign done_o         = (r_state == DONE);
  assign unstable_cnt_o = r_unst;
  assign first_bad_o    = r_first_bad;
  assign bad_valid_o    = r_bad_valid;

endmodule
